// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one shared 4-bit adder stage walks the operands
// low nibble first, linking nibbles through a registered carry.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // WIDTH must be a multiple of 4 and at least 4.
  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              c_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              out_valid_q;

  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [4:0]        nib_sum;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE, out_valid only in DONE, so an
  // accept and a drain can never share an edge.
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign dbg_state = state_q;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= carry_in;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
              sum_q[4*k +: 4] <= nib_sum[3:0];
            end
          end
          c_q <= nib_sum[4];
          if (idx_q == IDX_LAST) begin
            cout_q      <= nib_sum[4];
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          // Result stays put until the sink takes it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboarded bench for nibble_serial_adder at WIDTH=16: directed corner
// cases, back-pressure, reset abort and a random sweep with sink stalls.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int sink_mode = 0;  // 0: always ready, 1: random stalls, 2: held off

  logic [W:0]   exp_q[$];
  logic         prev_valid;
  logic [W:0]   prev_res;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic ci);
    return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
  endfunction

  // driver: present operands from a falling edge, hold until accepted
  task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         output int waited);
    @(negedge clk);
    a = av;
    b = bv;
    carry_in = ci;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", {{W{1'b0}}, in_ready}, (W+1)'(1));
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(av, bv, ci));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 50);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {{W{1'b0}}, in_ready}, (W+1)'(1));
  endtask

  // sink + scoreboard: ready is chosen first, then a handshake at the coming edge pops
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (prev_valid && out_valid) begin
        check("hold_stable", {carry_out, sum}, prev_res);
      end
      if (out_valid) begin
        check("in_ready_in_done", {{W{1'b0}}, in_ready}, '0);
      end
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {{W{1'b0}}, out_valid}, '0);
          end else begin
            check("result", {carry_out, sum}, exp_q.pop_front());
          end
          prev_valid = 1'b0;
        end else begin
          prev_valid = 1'b1;
          prev_res = {carry_out, sum};
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    int w;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         ci;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    carry_in = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sum", {carry_out, sum}, '0);
    check("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
    check("rst_busy", {{W{1'b0}}, busy}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));

    // full carry ripple and latency
    sink_mode = 0;
    send_op(16'hFFFF, 16'h0001, 1'b0, w);
    wait_valid(lat);
    check("latency", (W+1)'(lat), (W+1)'(N));
    check("ffff_plus_1", {carry_out, sum}, 17'h10000);
    wait_idle();

    send_op(16'h1234, 16'h4321, 1'b1, w);
    wait_valid(lat);
    check("1234_4321_c1", {carry_out, sum}, 17'h05556);
    wait_idle();

    send_op(16'h000F, 16'h0000, 1'b1, w);
    wait_valid(lat);
    check("000f_c1", {carry_out, sum}, 17'h00010);
    wait_idle();

    // back-pressure in DONE
    sink_mode = 2;
    send_op(16'hA5A5, 16'h5A5B, 1'b0, w);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {{W{1'b0}}, out_valid}, (W+1)'(1));
      check("stall_value", {carry_out, sum}, model(16'hA5A5, 16'h5A5B, 1'b0));
      check("stall_in_ready", {{W{1'b0}}, in_ready}, '0);
      check("stall_state", {{(W-1){1'b0}}, dbg_state}, (W+1)'(2));
    end
    sink_mode = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("release_valid", {{W{1'b0}}, out_valid}, '0);
    check("release_in_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));

    // new operands during RUN must be ignored
    send_op(16'h0F0F, 16'h0101, 1'b0, w);
    a = 16'hFFFF;
    b = 16'hFFFF;
    carry_in = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("run_busy", {{W{1'b0}}, busy}, (W+1)'(1));
    check("run_in_ready", {{W{1'b0}}, in_ready}, '0);
    send_op(16'hFFFF, 16'hFFFF, 1'b1, w);
    check("second_waits", {{W{1'b0}}, w >= N - 1}, (W+1)'(1));
    wait_idle();

    // reset in RUN at idx 2 aborts the operation
    send_op(16'hABCD, 16'h1111, 1'b0, w);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_abort_state", {{(W-1){1'b0}}, dbg_state}, (W+1)'(1));
    rst_n = 1'b0;
    #1;
    check("abort_sum", {carry_out, sum}, '0);
    check("abort_out_valid", {{W{1'b0}}, out_valid}, '0);
    check("abort_busy", {{W{1'b0}}, busy}, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {{W{1'b0}}, in_ready}, (W+1)'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", {{W{1'b0}}, out_valid}, '0);
    end

    // random sweep with sink stalls
    sink_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      ci = 1'($urandom_range(0, 1));
      if (i % 16 == 0) av = '1;
      if (i % 23 == 0) bv = '1;
      send_op(av, bv, ci, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    sink_mode = 0;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", (W+1)'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
